// File: rtl/riscv_dtm_dmi_ctrl.sv
// DTM data-register back end: dtmcs and dmi scan registers plus the DMI
// request/response engine with timeout, sticky status and hard reset.
module riscv_dtm_dmi_ctrl #(
  parameter int unsigned ABITS       = 7,
  parameter int unsigned IDLE_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             tdi_i,
  input  logic             shift_dr_i,
  input  logic             capture_dr_i,
  input  logic             update_dr_i,
  input  logic             dmi_select_i,
  input  logic             dtmcs_select_i,
  output logic             dmi_tdo_o,
  output logic             dtmcs_tdo_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [31:0]      resp_data_i,
  input  logic [1:0]       resp_op_i
);

  localparam int unsigned      DW      = ABITS + 34;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       IDLE_V  = 3'(IDLE_CYCLES);
  localparam logic [5:0]       ABITS_V = 6'(ABITS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      dmi_q, dmi_d;
  logic [31:0]        dtmcs_q, dtmcs_d;
  logic [1:0]         sticky_q, sticky_d;
  logic [2:0]         errinfo_q, errinfo_d;
  logic [31:0]        data_out_q, data_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ABITS-1:0]   req_addr_q, req_addr_d;
  logic [31:0]        req_data_q, req_data_d;
  logic [1:0]         req_op_q, req_op_d;

  logic dmi_shift, dmi_cap, dmi_upd;
  logic dtmcs_shift, dtmcs_cap, dtmcs_upd;
  logic timeout_hit;

  assign dmi_shift   = dmi_select_i & shift_dr_i;
  assign dmi_cap     = dmi_select_i & capture_dr_i;
  assign dmi_upd     = dmi_select_i & update_dr_i;
  assign dtmcs_shift = dtmcs_select_i & shift_dr_i;
  assign dtmcs_cap   = dtmcs_select_i & capture_dr_i;
  assign dtmcs_upd   = dtmcs_select_i & update_dr_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  assign req_valid_o  = (state_q == S_REQ);
  assign resp_ready_o = (state_q != S_REQ);
  assign req_addr_o   = req_addr_q;
  assign req_data_o   = req_data_q;
  assign req_op_o     = req_op_q;
  assign dmi_tdo_o    = dmi_q[0];
  assign dtmcs_tdo_o  = dtmcs_q[0];

  // Next-state: FSM first, then scan-register effects, then dtmcs resets
  // last so dtmhardreset/dmireset override anything the FSM did this edge.
  always_comb begin
    state_d    = state_q;
    dmi_d      = dmi_q;
    dtmcs_d    = dtmcs_q;
    sticky_d   = sticky_q;
    errinfo_d  = errinfo_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_op_d   = req_op_q;

    case (state_q)
      S_IDLE: begin
        if (dmi_upd && sticky_q == 2'd0 && (dmi_q[1:0] == 2'd1 || dmi_q[1:0] == 2'd2)) begin
          req_addr_d = dmi_q[DW-1:34];
          req_data_d = dmi_q[33:2];
          req_op_d   = dmi_q[1:0];
          cnt_d      = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == S_REQ && req_ready_i) begin
          state_d = S_WAIT;
        end else if (state_q == S_WAIT && resp_valid_i) begin
          data_out_d = resp_data_i;
          if (sticky_q == 2'd0) sticky_d = resp_op_i;
          if (resp_op_i == 2'd2) errinfo_d = 3'd2 + 3'd1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          if (sticky_q == 2'd0) sticky_d = 2'd2;
          errinfo_d  = 3'd2;
          data_out_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (dmi_shift) begin
      dmi_d = {tdi_i, dmi_q[DW-1:1]};
    end else if (dmi_cap) begin
      if (state_q != S_IDLE) begin
        dmi_d[1:0] = 2'd3;
        if (sticky_q == 2'd0) sticky_d = 2'd3;
        errinfo_d = 3'd1;
      end else begin
        dmi_d[1:0]  = sticky_q;
        dmi_d[33:2] = data_out_q;
      end
    end

    if (dtmcs_shift) begin
      dtmcs_d = {tdi_i, dtmcs_q[31:1]};
    end else if (dtmcs_cap) begin
      dtmcs_d = {11'd0, errinfo_q, 2'd0, 1'b0, IDLE_V, sticky_q, ABITS_V, 4'd1};
    end else if (dtmcs_upd) begin
      if (dtmcs_q[17]) begin
        sticky_d   = '0;
        errinfo_d  = '0;
        state_d    = S_IDLE;
        data_out_d = '0;
        cnt_d      = '0;
      end else if (dtmcs_q[16]) begin
        sticky_d  = '0;
        errinfo_d = '0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q    <= S_IDLE;
      dmi_q      <= '0;
      dtmcs_q    <= '0;
      sticky_q   <= '0;
      errinfo_q  <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      dmi_q      <= dmi_d;
      dtmcs_q    <= dtmcs_d;
      sticky_q   <= sticky_d;
      errinfo_q  <= errinfo_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_op_q   <= req_op_d;
    end
  end

endmodule

// File: tb/tb_riscv_dtm_dmi_ctrl.sv
// Self-checking bench for riscv_dtm_dmi_ctrl: unit 0 uses ABITS=7, IDLE=1,
// TIMEOUT=1024; unit 1 uses ABITS=12, IDLE=5, TIMEOUT=8 (shares the TAP strobes).
module tb_riscv_dtm_dmi_ctrl;

  logic tck = 1'b0;
  logic trst = 1'b1;
  logic tdi = 1'b0, shift = 1'b0, capture = 1'b0, update = 1'b0;
  logic dmi_sel [2];
  logic dtmcs_sel [2];
  logic dmi_tdo [2];
  logic dtmcs_tdo [2];
  logic req_valid [2];
  logic req_ready [2];
  logic [31:0] req_data [2];
  logic [1:0] req_op [2];
  logic resp_valid [2];
  logic resp_ready [2];
  logic [31:0] resp_data [2];
  logic [1:0] resp_op [2];
  logic [6:0] addr_a;
  logic [11:0] addr_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  op;
    int          delay;
    logic [31:0] rdata;
    logic [1:0]  rop;
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
  } vec_t;
  vec_t vecs [4];

  always #5 tck = ~tck;

  riscv_dtm_dmi_ctrl #(.ABITS(7), .IDLE_CYCLES(1), .TIMEOUT(1024), .CNT_W(16)) u_a (
    .tck_i(tck), .trst_i(trst), .tdi_i(tdi), .shift_dr_i(shift), .capture_dr_i(capture),
    .update_dr_i(update), .dmi_select_i(dmi_sel[0]), .dtmcs_select_i(dtmcs_sel[0]),
    .dmi_tdo_o(dmi_tdo[0]), .dtmcs_tdo_o(dtmcs_tdo[0]), .req_valid_o(req_valid[0]),
    .req_ready_i(req_ready[0]), .req_addr_o(addr_a), .req_data_o(req_data[0]),
    .req_op_o(req_op[0]), .resp_valid_i(resp_valid[0]), .resp_ready_o(resp_ready[0]),
    .resp_data_i(resp_data[0]), .resp_op_i(resp_op[0])
  );

  riscv_dtm_dmi_ctrl #(.ABITS(12), .IDLE_CYCLES(5), .TIMEOUT(8), .CNT_W(4)) u_b (
    .tck_i(tck), .trst_i(trst), .tdi_i(tdi), .shift_dr_i(shift), .capture_dr_i(capture),
    .update_dr_i(update), .dmi_select_i(dmi_sel[1]), .dtmcs_select_i(dtmcs_sel[1]),
    .dmi_tdo_o(dmi_tdo[1]), .dtmcs_tdo_o(dtmcs_tdo[1]), .req_valid_o(req_valid[1]),
    .req_ready_i(req_ready[1]), .req_addr_o(addr_b), .req_data_o(req_data[1]),
    .req_op_o(req_op[1]), .resp_valid_i(resp_valid[1]), .resp_ready_o(resp_ready[1]),
    .resp_data_i(resp_data[1]), .resp_op_i(resp_op[1])
  );

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] get_addr(input int u);
    return (u == 0) ? {5'd0, addr_a} : addr_b;
  endfunction

  function automatic logic [63:0] mk_dmi(input int u, input logic [11:0] a,
                                         input logic [31:0] d, input logic [1:0] o);
    logic [63:0] r;
    r = '0;
    r[1:0] = o;
    r[33:2] = d;
    if (u == 0) r[40:34] = a[6:0];
    else r[45:34] = a;
    return r;
  endfunction

  // Capture, shift len bits (collecting tdo), update.
  task automatic scan(input int u, input bit is_dmi, input logic [63:0] din, output logic [63:0] dout);
    int len;
    len = is_dmi ? ((u == 0) ? 41 : 46) : 32;
    dout = '0;
    dmi_sel[u] = is_dmi;
    dtmcs_sel[u] = !is_dmi;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < len; i++) begin
      tdi = din[i];
      dout[i] = is_dmi ? dmi_tdo[u] : dtmcs_tdo[u];
      tick();
    end
    shift = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
    dmi_sel[u] = 1'b0;
    dtmcs_sel[u] = 1'b0;
  endtask

  task automatic dtmcs_rw(input int u, input string name, input logic [31:0] wr, input logic [31:0] exp);
    logic [63:0] d;
    scan(u, 1'b0, {32'd0, wr}, d);
    chk(name, d[31:0], exp);
  endtask

  // Nop dmi scan; compare captured data/op against the scoreboard head.
  task automatic readback(input int u, input string name);
    logic [63:0] d;
    exp_t e;
    scan(u, 1'b1, mk_dmi(u, 12'd0, 32'd0, 2'd0), d);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, d[33:2], e.data);
      chk({name, "_op"}, d[1:0], e.op);
    end
    chk({name, "_noreq"}, req_valid[u], 1'b0);
  endtask

  // DM model: check request, wait delay cycles, accept, then respond.
  task automatic dm_serve(input int u, input int delay, input logic [31:0] rdata, input logic [1:0] rop,
                          input logic [11:0] ea, input logic [31:0] ed, input logic [1:0] eo);
    int n = 0;
    while (!req_valid[u] && n < 10) begin
      tick();
      n++;
    end
    chk("req_valid", req_valid[u], 1'b1);
    chk("resp_ready_in_req", resp_ready[u], 1'b0);
    chk("req_addr", get_addr(u), ea);
    chk("req_data", req_data[u], ed);
    chk("req_op", req_op[u], eo);
    for (int i = 0; i < delay; i++) tick();
    chk("req_stable", {get_addr(u), req_data[u], req_op[u], req_valid[u]}, {ea, ed, eo, 1'b1});
    req_ready[u] = 1'b1;
    tick();
    req_ready[u] = 1'b0;
    chk("wait_resp_ready", resp_ready[u], 1'b1);
    chk("wait_no_valid", req_valid[u], 1'b0);
    resp_valid[u] = 1'b1;
    resp_data[u] = rdata;
    resp_op[u] = rop;
    tick();
    resp_valid[u] = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    int n;

    vecs[0] = '{addr: 12'h010, wdata: 32'h0, op: 2'd1, delay: 2, rdata: 32'hDEADBEEF, rop: 2'd0,
                exp_data: 32'hDEADBEEF, exp_op: 2'd0};
    vecs[1] = '{addr: 12'h022, wdata: 32'hCAFEF00D, op: 2'd2, delay: 0, rdata: 32'h0, rop: 2'd0,
                exp_data: 32'h0, exp_op: 2'd0};
    vecs[2] = '{addr: 12'h07F, wdata: 32'h0, op: 2'd1, delay: 5, rdata: 32'h13579BDF, rop: 2'd0,
                exp_data: 32'h13579BDF, exp_op: 2'd0};
    vecs[3] = '{addr: 12'h001, wdata: 32'hFFFFFFFF, op: 2'd2, delay: 1, rdata: 32'hA5A5A5A5, rop: 2'd0,
                exp_data: 32'hA5A5A5A5, exp_op: 2'd0};

    for (int u = 0; u < 2; u++) begin
      dmi_sel[u] = 1'b0; dtmcs_sel[u] = 1'b0; req_ready[u] = 1'b0;
      resp_valid[u] = 1'b0; resp_data[u] = '0; resp_op[u] = '0;
    end
    tick();
    tick();
    trst = 1'b0;
    tick();

    // Reset state.
    for (int u = 0; u < 2; u++) begin
      chk("rst_req_valid", req_valid[u], 1'b0);
      chk("rst_resp_ready", resp_ready[u], 1'b1);
      chk("rst_tdo", {dmi_tdo[u], dtmcs_tdo[u]}, 2'b00);
      chk("rst_req", {get_addr(u), req_data[u], req_op[u]}, 46'd0);
    end
    dtmcs_rw(0, "dtmcs_a_init", 32'd0, 32'h00001071);
    dtmcs_rw(1, "dtmcs_b_init", 32'd0, 32'h000050C1);

    // Table-driven requests on unit 0.
    foreach (vecs[i]) begin
      scan(0, 1'b1, mk_dmi(0, vecs[i].addr, vecs[i].wdata, vecs[i].op), d);
      sb.push_back('{data: vecs[i].exp_data, op: vecs[i].exp_op});
      dm_serve(0, vecs[i].delay, vecs[i].rdata, vecs[i].rop, vecs[i].addr,
               (vecs[i].op == 2'd2) ? vecs[i].wdata : 32'h0, vecs[i].op);
      readback(0, "vec");
    end

    // Busy: capture while WAIT.
    scan(0, 1'b1, mk_dmi(0, 12'h05, 32'h0, 2'd1), d);
    n = 0;
    while (!req_valid[0] && n < 10) begin tick(); n++; end
    req_ready[0] = 1'b1;
    tick();
    req_ready[0] = 1'b0;
    scan(0, 1'b1, mk_dmi(0, 12'h06, 32'h0, 2'd1), d);
    chk("busy_op", d[1:0], 2'd3);
    chk("busy_still_wait", {req_valid[0], resp_ready[0]}, 2'b01);
    resp_valid[0] = 1'b1; resp_data[0] = 32'h11112222; resp_op[0] = 2'd0;
    tick();
    resp_valid[0] = 1'b0;
    scan(0, 1'b1, mk_dmi(0, 12'h07, 32'h0, 2'd1), d);
    chk("busy_sticky_op", d[1:0], 2'd3);
    chk("busy_data", d[33:2], 32'h11112222);
    for (int i = 0; i < 3; i++) begin
      chk("busy_upd_ignored", req_valid[0], 1'b0);
      tick();
    end
    dtmcs_rw(0, "busy_dtmcs", 32'h00010000, 32'h00041C71);
    dtmcs_rw(0, "busy_cleared", 32'd0, 32'h00001071);

    // Hardreset during REQ.
    scan(0, 1'b1, mk_dmi(0, 12'h33, 32'h1, 2'd2), d);
    chk("hr_req_valid", req_valid[0], 1'b1);
    dtmcs_rw(0, "hr_dtmcs_before", 32'h00020000, 32'h00001071);
    chk("hr_valid_dropped", req_valid[0], 1'b0);
    chk("hr_resp_ready", resp_ready[0], 1'b1);
    dtmcs_rw(0, "hr_dtmcs_after", 32'd0, 32'h00001071);
    sb.push_back('{data: 32'h0, op: 2'd0});
    readback(0, "hr_dataout");

    // Failed op: sticky 2, errinfo 3.
    scan(0, 1'b1, mk_dmi(0, 12'h40, 32'h0, 2'd1), d);
    dm_serve(0, 0, 32'hBAD0BAD0, 2'd2, 12'h40, 32'h0, 2'd1);
    scan(0, 1'b1, mk_dmi(0, 12'h41, 32'h0, 2'd1), d);
    chk("fail_op", d[1:0], 2'd2);
    chk("fail_data", d[33:2], 32'hBAD0BAD0);
    for (int i = 0; i < 3; i++) begin
      chk("fail_upd_ignored", req_valid[0], 1'b0);
      tick();
    end
    resp_valid[0] = 1'b1; resp_data[0] = 32'h0; resp_op[0] = 2'd0;
    chk("stray_resp_ready", resp_ready[0], 1'b1);
    tick();
    resp_valid[0] = 1'b0;
    dtmcs_rw(0, "fail_dtmcs", 32'h00010000, 32'h000C1871);
    dtmcs_rw(0, "fail_cleared", 32'd0, 32'h00001071);

    // Width: ABITS=12 unit.
    scan(1, 1'b1, mk_dmi(1, 12'hABC, 32'h5A5A1234, 2'd2), d);
    sb.push_back('{data: 32'h0F0F0F0F, op: 2'd0});
    dm_serve(1, 1, 32'h0F0F0F0F, 2'd0, 12'hABC, 32'h5A5A1234, 2'd2);
    readback(1, "wide");

    // Timeout: TIMEOUT=8, DM never ready.
    scan(1, 1'b1, mk_dmi(1, 12'h003, 32'h0, 2'd1), d);
    n = 0;
    while (req_valid[1] && n < 20) begin n++; tick(); end
    chk("timeout_cycles", n, 8);
    chk("timeout_resp_ready", resp_ready[1], 1'b1);
    dtmcs_rw(1, "timeout_dtmcs", 32'd0, 32'h000858C1);
    resp_valid[1] = 1'b1; resp_data[1] = 32'h12345678; resp_op[1] = 2'd0;
    chk("late_resp_ready", resp_ready[1], 1'b1);
    tick();
    resp_valid[1] = 1'b0;
    sb.push_back('{data: 32'h0, op: 2'd2});
    readback(1, "late_dropped");
    dtmcs_rw(1, "timeout_reset", 32'h00010000, 32'h000858C1);
    dtmcs_rw(1, "timeout_cleared", 32'd0, 32'h000050C1);

    // Asynchronous reset mid-request.
    scan(0, 1'b1, mk_dmi(0, 12'h11, 32'h0, 2'd1), d);
    chk("trst_pre_valid", req_valid[0], 1'b1);
    #2 trst = 1'b1;
    #1 chk("trst_async_drop", req_valid[0], 1'b0);
    tick();
    trst = 1'b0;
    tick();
    chk("trst_resp_ready", resp_ready[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
